// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue
//  Description : Instruction fetch queue between fetch and decode. Holds
//                {inst, inst_addr} pairs in a small first-word-fall-through
//                FIFO, back-pressures fetch when full, and empties in one
//                cycle on a pipeline flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter logic [DW-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     I_push,
    input  logic [DW-1:0]            I_inst,
    input  logic [AW-1:0]            I_inst_addr,
    input  logic                     I_pop,
    input  logic                     I_flush,
    output logic                     O_valid,
    output logic [DW-1:0]            O_inst,
    output logic [AW-1:0]            O_inst_addr,
    output logic                     O_full,
    output logic [$clog2(DEPTH):0]   O_count,
    output logic                     O_overflow
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [DW-1:0]   r_mem_inst [DEPTH];
    logic [AW-1:0]   r_mem_addr [DEPTH];
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_pop_ok;
    logic            w_push_ok;
    logic            w_drop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_pop_ok  = I_pop & ~w_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = I_push & (~w_full | w_pop_ok);
    // Pushes discarded by a flush are intentional, so they do not count as drops.
    assign w_drop    = I_push & ~w_push_ok & ~I_flush;

    // Pointer, occupancy and sticky-overflow state; rst beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (I_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + c_CW'(w_push_ok) - c_CW'(w_pop_ok);
            end
        end
    end

    // Entry storage; deliberately not reset, validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (!rst && !I_flush && w_push_ok) begin
            r_mem_inst[r_wr_ptr] <= I_inst;
            r_mem_addr[r_wr_ptr] <= I_inst_addr;
        end
    end

    // Head presentation is purely from registered state; NOP/0 when empty.
    always_comb begin
        O_inst      = NOP_INST;
        O_inst_addr = '0;
        if (!w_empty) begin
            O_inst      = r_mem_inst[r_rd_ptr];
            O_inst_addr = r_mem_addr[r_rd_ptr];
        end
    end

    assign O_valid    = ~w_empty;
    assign O_full     = w_full;
    assign O_count    = r_count;
    assign O_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_queue
//  Description : Directed self-checking bench for inst_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

    localparam int c_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        push;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        pop;
    logic        flush;
    logic        valid;
    logic [31:0] head_inst;
    logic [31:0] head_addr;
    logic        full;
    logic [2:0]  count;
    logic        overflow;

    int n_checks;
    int n_errors;

    inst_queue #(
        .DEPTH    (c_DEPTH),
        .AW       (32),
        .DW       (32),
        .NOP_INST (32'h0000_0013)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .I_push      (push),
        .I_inst      (inst),
        .I_inst_addr (inst_addr),
        .I_pop       (pop),
        .I_flush     (flush),
        .O_valid     (valid),
        .O_inst      (head_inst),
        .O_inst_addr (head_addr),
        .O_full      (full),
        .O_count     (count),
        .O_overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1ns after the edge.
    task automatic cyc(input logic p, input logic [31:0] i, input logic [31:0] a,
                       input logic q, input logic f);
        push      = p;
        inst      = i;
        inst_addr = a;
        pop       = q;
        flush     = f;
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] ei, input logic [31:0] ea);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_inst"},  head_inst, ei);
        chk({tag, "_addr"},  head_addr, ea);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_inst"},  head_inst, 32'h13);
        chk({tag, "_addr"},  head_addr, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; push = 1'b0; inst = '0; inst_addr = '0; pop = 1'b0; flush = 1'b0;

        // 1. reset
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk_empty("rst");
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        // 2. fill to full, then overflow
        cyc(1, 32'hA0, 32'h8000_0000, 0, 0);
        chk_head("fill0", 32'hA0, 32'h8000_0000);
        chk("fill0_count", 32'(count), 32'd1);
        for (int k = 1; k < 4; k++) begin
            cyc(1, 32'hA0 + 32'(k), 32'h8000_0000 + 32'(4 * k), 0, 0);
            chk("fill_full", 32'(full), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("full_count", 32'(count), 32'd4);
        chk_head("full", 32'hA0, 32'h8000_0000);
        chk("full_ovf", 32'(overflow), 32'd0);
        cyc(1, 32'hFF, 32'h8000_0010, 0, 0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk_head("ovf", 32'hA0, 32'h8000_0000);

        // 3. push+pop while full, then drain
        cyc(1, 32'hA4, 32'h8000_0010, 1, 0);
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_full", 32'(full), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk_head("drain", 32'hA1 + 32'(k), 32'h8000_0004 + 32'(4 * k));
            cyc(0, 0, 0, 1, 0);
        end
        chk_empty("drained");
        chk("drained_full", 32'(full), 32'd0);

        // 4. staggered push/pop across pointer wrap
        cyc(1, 32'hC0, 32'h1000, 0, 0);
        chk_head("stag0", 32'hC0, 32'h1000);
        for (int k = 1; k < 10; k++) begin
            cyc(1, 32'hC0 + 32'(k), 32'h1000 + 32'(4 * k), 1, 0);
            chk_head("stag", 32'hC0 + 32'(k), 32'h1000 + 32'(4 * k));
            chk("stag_count", 32'(count), 32'd1);
        end
        cyc(0, 0, 0, 1, 0);
        chk_empty("stag_end");

        // 5. flush with simultaneous push and pop
        cyc(1, 32'hB1, 32'h2000, 0, 0);
        cyc(1, 32'hB2, 32'h2004, 0, 0);
        cyc(1, 32'hB3, 32'h2008, 0, 0);
        chk("pre_flush_count", 32'(count), 32'd3);
        cyc(1, 32'hEE, 32'h200C, 1, 1);
        chk_empty("flush");
        chk("flush_ovf", 32'(overflow), 32'd1);
        cyc(1, 32'hB0, 32'h3000, 0, 0);
        chk_head("post_flush", 32'hB0, 32'h3000);
        chk("post_flush_count", 32'(count), 32'd1);

        // 6. pop on empty, then reset mid-operation
        cyc(0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 0);
            chk_empty("empty_pop");
        end
        cyc(1, 32'hD0, 32'h4000, 0, 0);
        chk_head("after_empty_pop", 32'hD0, 32'h4000);
        cyc(1, 32'hD1, 32'h4004, 0, 0);
        chk("pre_rst_count", 32'(count), 32'd2);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        rst = 1'b1;
        cyc(1, 32'hD2, 32'h4008, 1, 0);
        chk_empty("mid_rst");
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        rst = 1'b0;
        cyc(1, 32'hE0, 32'h5000, 0, 0);
        chk_head("after_rst", 32'hE0, 32'h5000);
        chk("after_rst_count", 32'(count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
